// File: rtl/pipe_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_mux_pkg                                                             |
// | Shared definitions for the pipe_mux_n operand selector: select-width     |
// | helper, skid-buffer state encoding and NUM_IN legality bounds.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_mux_pkg;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; used to size the select field.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_n                                                                    |
// | Combinational N-way word selector. Returns zero and raises oor_o when    |
// | the select index has no corresponding input.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    oor_o
);

  localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

  // Pick the addressed word; an unmatched index leaves the zero default.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) data_o = data_i[k*WIDTH +: WIDTH];
    end
    oor_o = ({1'b0, sel_i} >= c_num_in);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_mux_n                                                               |
// | N-way operand selector with a registered valid/ready output stage,       |
// | flush and out-of-range select flagging.                                  |
// | Build option PIPE_MUX_SKID_EN: two-entry skid buffer with registered     |
// | in_ready; otherwise a single output register with combinational ready.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
);

  generate
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_num_in_illegal
      $error("pipe_mux_n: NUM_IN outside legal range");
    end
  endgenerate

  logic [WIDTH-1:0] w_word;
  logic             w_oor;
  logic             w_accept;
  logic             w_transfer;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .sel_i  (sel),
    .data_i (in_data),
    .data_o (w_word),
    .oor_o  (w_oor)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;

  // Main output register, common to both builds.
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;

  assign out_data = data_q;
  assign out_sel  = sel_q;
  assign sel_err  = err_q;

`ifdef PIPE_MUX_SKID_EN
  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d;

  // Ready comes from a flop; rst and flush only mask it, out_ready never reaches it.
  assign in_ready  = rdy_q && !rst && !flush;
  assign out_valid = (state_q != EMPTY);

  // Next-state: new words fill main first, overflow into skid, skid refills main.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    err_d       = err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (w_accept) begin
          state_d = ONE;
          data_d  = w_word;
          sel_d   = sel;
          err_d   = w_oor;
        end
      end
      ONE: begin
        if (w_accept && w_transfer) begin
          data_d = w_word;
          sel_d  = sel;
          err_d  = w_oor;
        end else if (w_accept) begin
          state_d     = FULL;
          skid_data_d = w_word;
          skid_sel_d  = sel;
          skid_err_d  = w_oor;
        end else if (w_transfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (w_transfer) begin
          state_d = ONE;
          data_d  = skid_data_q;
          sel_d   = skid_sel_q;
          err_d   = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      data_d      = '0;
      sel_d       = '0;
      err_d       = 1'b0;
      skid_data_d = '0;
      skid_sel_d  = '0;
      skid_err_d  = 1'b0;
    end
    rdy_d = (state_d != FULL);
  end

  // State and storage registers; reset leaves the buffer empty and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      rdy_q       <= 1'b1;
      data_q      <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
    end
  end
`else
  logic valid_q, valid_d;

  // Room exists when empty or when the held word leaves this cycle.
  assign in_ready  = !rst && !flush && (!valid_q || out_ready);
  assign out_valid = valid_q;

  // Next-state: flush empties, accept overwrites, lone transfer empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = err_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      sel_d   = '0;
      err_d   = 1'b0;
    end else if (w_accept) begin
      valid_d = 1'b1;
      data_d  = w_word;
      sel_d   = sel;
      err_d   = w_oor;
    end else if (w_transfer) begin
      valid_d = 1'b0;
    end
  end

  // Single output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_mux_n                                                            |
// | Scoreboard bench for pipe_mux_n with WIDTH=32, NUM_IN=5.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_mux_n;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [WIDTH+SEL_W:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .sel_err   (sel_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Input k carries 0x1000_0000+k; indices 5..7 select nothing.
  function automatic logic [WIDTH+SEL_W:0] exp_word(input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] d;
    d = (s < 3'd5) ? (32'h1000_0000 + 32'(s)) : 32'h0;
    return {d, s, (s >= 3'd5)};
  endfunction

  // Monitor: a transfer happens at the next edge when valid&&ready now.
  always @(negedge clk) begin
    if (rst === 1'b1 || flush === 1'b1) begin
      sb_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h sel %0d, expected no word", out_data, out_sel);
        end else begin
          check("scoreboard", {out_data, out_sel, sel_err}, sb_q.pop_front());
          n_pops++;
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(exp_word(sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd3;
    out_ready = 1'b1;
    for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(k);

    // Reset held three cycles with traffic offered.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 0);
    end
    check("rst_out_sel", out_sel, 0);
    check("rst_sel_err", sel_err, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Basic select, one-cycle latency.
    sel = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 32'h1000_0003);
    check("basic_sel", out_sel, 3);
    check("basic_err", sel_err, 0);
    out_ready = 1'b1;
    step();
    check("basic_drained", out_valid, 0);

    // Out-of-range select.
    sel = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("oor_valid", out_valid, 1);
    check("oor_data", out_data, 0);
    check("oor_sel", out_sel, 6);
    check("oor_err", sel_err, 1);
    step();

    // Backpressure: held word stays put; skid build takes one more.
    sel = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    sel = 3'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_hold_data", out_data, 32'h1000_0001);
      check("bp_hold_valid", out_valid, 1);
`ifdef PIPE_MUX_SKID_EN
      check("bp_in_ready", in_ready, (i == 0) ? 1 : 0);
`else
      check("bp_in_ready", in_ready, 0);
`endif
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("bp_drained", sb_q.size(), 0);

    // Flush while holding a word, with a new word offered.
    sel = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    flush = 1'b1; sel = 3'd2;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_nothing_left", sb_q.size(), 0);

    // Reset in the middle of a held word.
    sel = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    out_ready = 1'b1;
    step();
    check("midrst_still_empty", out_valid, 0);

    // Streaming: 20 words, one per cycle.
    pops0 = n_pops;
    for (int i = 0; i < 20; i++) begin
      sel = 3'(i % 5);
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1);
      if (i > 0) begin
        check("stream_valid", out_valid, 1);
        check("stream_data", out_data, 32'h1000_0000 + 32'((i - 1) % 5));
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_last_data", out_data, 32'h1000_0004);
    step();
    check("stream_count", n_pops - pops0, 20);
    check("stream_end_valid", out_valid, 0);
    check("stream_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
